// File: rtl/fpu_config_loader.sv
// Polls the start register, then fetches dimensions, addresses and filter taps into shadow
// registers. The shadows are committed to the outputs together, so the FPU controller never sees a partial configuration.
module fpu_config_loader #(
  parameter int          KERNEL_DIM = 3,
  parameter int          TAP_WIDTH  = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic [ADDR_WIDTH-1:0]                    address_mem,
  output logic                                     mem_rd_req,
  input  logic [DATA_WIDTH-1:0]                    data_mem,
  input  logic                                     mapped_data_valid,
  input  logic                                     fpu_done,
  output logic [15:0]                              image_width,
  output logic [15:0]                              image_height,
  output logic [31:0]                              start_address,
  output logic [31:0]                              result_address,
  output logic [KERNEL_DIM*KERNEL_DIM*TAP_WIDTH-1:0] filter,
  output logic                                     load_config_done,
  output logic                                     busy,
  output logic                                     cfg_error
);

  localparam int NUM_TAPS      = KERNEL_DIM * KERNEL_DIM;
  localparam int FILT_BITS     = NUM_TAPS * TAP_WIDTH;
  localparam int NUM_WORDS     = (FILT_BITS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int TAPS_PER_WORD = DATA_WIDTH / TAP_WIDTH;
  localparam int WORD_IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [31:0] OFF_DIMS     = 32'h000;
  localparam logic [31:0] OFF_START    = 32'h020;
  localparam logic [31:0] OFF_FILTER   = 32'h040;
  localparam logic [31:0] OFF_RESULT   = 32'h100;
  localparam logic [31:0] OFF_STARTSIG = 32'h120;

  typedef enum logic [2:0] {
    S_POLL, S_DIMS, S_START, S_RESULT, S_FILT, S_COMMIT, S_RUN, S_ERR
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_req;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_armed;
  logic [WORD_IDX_W-1:0]   r_word;
  logic [15:0]             r_sh_width;
  logic [15:0]             r_sh_height;
  logic [31:0]             r_sh_start;
  logic [31:0]             r_sh_result;
  logic [FILT_BITS-1:0]    r_sh_filter;
  logic [15:0]             r_width;
  logic [15:0]             r_height;
  logic [31:0]             r_start;
  logic [31:0]             r_result;
  logic [FILT_BITS-1:0]    r_filter;
  logic                    r_done;
  logic                    r_busy;
  logic                    r_cfg_error;

  logic                    w_rd_done;
  logic                    w_read_state;
  logic                    w_start_seen;
  logic                    w_zero_dim;
  logic [31:0]             w_addr_off;

  // A response only counts while our request is outstanding; stray strobes are dropped here.
  assign w_rd_done    = r_req & mapped_data_valid;
  assign w_start_seen = |data_mem;
  assign w_zero_dim   = (r_sh_width == 16'd0) || (r_sh_height == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_POLL;
    else     r_state <= w_state_next;
  end

  // NOTE: every signal assigned in this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_read_state = 1'b0;
    w_addr_off   = OFF_STARTSIG;
    case (r_state)
      S_POLL: begin
        w_read_state = 1'b1;
        if (w_rd_done && w_start_seen && r_armed) w_state_next = S_DIMS;
      end
      S_DIMS: begin
        w_read_state = 1'b1;
        w_addr_off   = OFF_DIMS;
        if (w_rd_done) w_state_next = S_START;
      end
      S_START: begin
        w_read_state = 1'b1;
        w_addr_off   = OFF_START;
        if (w_rd_done) w_state_next = S_RESULT;
      end
      S_RESULT: begin
        w_read_state = 1'b1;
        w_addr_off   = OFF_RESULT;
        if (w_rd_done) w_state_next = S_FILT;
      end
      S_FILT: begin
        w_read_state = 1'b1;
        w_addr_off   = OFF_FILTER + (32'(r_word) << 2);
        if (w_rd_done && (r_word == WORD_IDX_W'(NUM_WORDS - 1))) w_state_next = S_COMMIT;
      end
      S_COMMIT: w_state_next = w_zero_dim ? S_ERR : S_RUN;
      S_RUN:    if (fpu_done) w_state_next = S_POLL;
      S_ERR:    w_state_next = S_POLL;
      default:  w_state_next = S_POLL;
    endcase
  end

  // NOTE: shadow and output registers are reset too, so a mid-fetch reset leaves no stale fields behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_armed     <= 1'b1;
      r_word      <= '0;
      r_sh_width  <= '0;
      r_sh_height <= '0;
      r_sh_start  <= '0;
      r_sh_result <= '0;
      r_sh_filter <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_start     <= '0;
      r_result    <= '0;
      r_filter    <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_read_state && !r_req) begin
        r_req  <= 1'b1;
        r_addr <= ADDR_WIDTH'(BASE_ADDR + w_addr_off);
      end else if (w_rd_done) begin
        r_req <= 1'b0;
      end

      if (r_state != S_FILT) r_word <= '0;

      if (w_rd_done) begin
        case (r_state)
          S_POLL: begin
            if (!w_start_seen)  r_armed <= 1'b1;
            else if (r_armed)   r_busy  <= 1'b1;
          end
          S_DIMS: begin
            r_sh_width  <= data_mem[31:16];
            r_sh_height <= data_mem[15:0];
          end
          S_START:  r_sh_start  <= data_mem[31:0];
          S_RESULT: r_sh_result <= data_mem[31:0];
          S_FILT: begin
            // Taps are packed MSB-first; bits past the last tap in the final word are pad.
            for (int i = 0; i < NUM_TAPS; i++) begin
              if (r_word == WORD_IDX_W'(i / TAPS_PER_WORD))
                r_sh_filter[i*TAP_WIDTH +: TAP_WIDTH] <=
                  data_mem[DATA_WIDTH-1-(i%TAPS_PER_WORD)*TAP_WIDTH -: TAP_WIDTH];
            end
            r_word <= r_word + WORD_IDX_W'(1);
          end
          default: ;
        endcase
      end

      case (r_state)
        S_COMMIT: begin
          if (w_zero_dim) begin
            r_cfg_error <= 1'b1;
          end else begin
            r_width     <= r_sh_width;
            r_height    <= r_sh_height;
            r_start     <= r_sh_start;
            r_result    <= r_sh_result;
            r_filter    <= r_sh_filter;
            r_done      <= 1'b1;
            r_cfg_error <= 1'b0;
          end
        end
        S_RUN: begin
          if (fpu_done) begin
            r_busy  <= 1'b0;
            r_armed <= 1'b0;
          end
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_armed <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign address_mem      = r_addr;
  assign mem_rd_req       = r_req;
  assign image_width      = r_width;
  assign image_height     = r_height;
  assign start_address    = r_start;
  assign result_address   = r_result;
  assign filter           = r_filter;
  assign load_config_done = r_done;
  assign busy             = r_busy;
  assign cfg_error        = r_cfg_error;

endmodule

// File: tb/tb_fpu_config_loader.sv
// Directed bench for fpu_config_loader: a 3x3 instance and a 5x5 instance share clock and reset
// and are served by a random-latency memory responder.
module tb_fpu_config_loader;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_a, req_b;
  logic [31:0] addr_a, addr_b;
  logic        fpu_a, fpu_b;
  logic [15:0] w_a, h_a, w_b, h_b;
  logic [31:0] sa_a, ra_a, sa_b, ra_b;
  logic [71:0] filt_a;
  logic [199:0] filt_b;
  logic        done_a, done_b, busy_a, busy_b, err_a, err_b;

  logic        valid_s [2];
  logic [31:0] data_s  [2];

  logic [31:0] startsig [2];
  logic [31:0] dims     [2];
  logic [31:0] startv   [2];
  logic [31:0] resv     [2];
  logic [31:0] filtw    [2][7];

  logic        pend     [2];
  logic        gave     [2];
  logic        spur     [2];
  logic [31:0] pend_addr[2];
  int          lat_cnt  [2];
  int          zero_cnt [2];
  int          done_cnt [2];
  int          lat_fix;
  logic [31:0] alog0[$];
  logic [31:0] alog1[$];

  int errors = 0;
  int checks = 0;

  fpu_config_loader #(.KERNEL_DIM(3)) dut_a (
    .clk(clk), .rst(rst),
    .address_mem(addr_a), .mem_rd_req(req_a),
    .data_mem(data_s[0]), .mapped_data_valid(valid_s[0]),
    .fpu_done(fpu_a),
    .image_width(w_a), .image_height(h_a),
    .start_address(sa_a), .result_address(ra_a),
    .filter(filt_a),
    .load_config_done(done_a), .busy(busy_a), .cfg_error(err_a)
  );

  fpu_config_loader #(.KERNEL_DIM(5)) dut_b (
    .clk(clk), .rst(rst),
    .address_mem(addr_b), .mem_rd_req(req_b),
    .data_mem(data_s[1]), .mapped_data_valid(valid_s[1]),
    .fpu_done(fpu_b),
    .image_width(w_b), .image_height(h_b),
    .start_address(sa_b), .result_address(ra_b),
    .filter(filt_b),
    .load_config_done(done_b), .busy(busy_b), .cfg_error(err_b)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lookup(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off == 32'h120) return startsig[d];
    if (off == 32'h000) return dims[d];
    if (off == 32'h020) return startv[d];
    if (off == 32'h100) return resv[d];
    if (off >= 32'h040 && off < 32'h05C) return filtw[d][int'((off - 32'h40) >> 2)];
    return 32'hBAD0_BAD0;
  endfunction

  // Memory responder: everything changes on the falling edge, away from the DUT's capture edge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      valid_s[d] = 1'b0; data_s[d] = '0; pend[d] = 1'b0; gave[d] = 1'b0;
      zero_cnt[d] = 0; lat_cnt[d] = 0; pend_addr[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic        rq;
        logic [31:0] ad;
        rq = (d == 0) ? req_a : req_b;
        ad = (d == 0) ? addr_a : addr_b;
        valid_s[d] = 1'b0;
        if (rst) begin
          pend[d] = 1'b0;
          gave[d] = 1'b0;
        end else if (pend[d]) begin
          if (lat_cnt[d] == 0) begin
            valid_s[d] = 1'b1;
            data_s[d]  = lookup(d, pend_addr[d]);
            if (pend_addr[d] == BASE + 32'h120 && data_s[d] == 32'h0) zero_cnt[d]++;
            pend[d] = 1'b0;
            gave[d] = 1'b1;
          end else begin
            lat_cnt[d]--;
          end
        end else if (rq) begin
          pend[d]      = 1'b1;
          pend_addr[d] = ad;
          lat_cnt[d]   = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 9));
          if (d == 0) alog0.push_back(ad);
          else        alog1.push_back(ad);
        end else if (gave[d] && spur[d]) begin
          valid_s[d] = 1'b1;
          data_s[d]  = 32'hFFFF_FFFF;
          gave[d]    = 1'b0;
        end else begin
          gave[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    forever begin
      @(posedge clk);
      if (done_a === 1'b1) done_cnt[0]++;
      if (done_b === 1'b1) done_cnt[1]++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_done(input int d, input int target);
    int n = 0;
    while (done_cnt[d] < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("load count d%0d", d), 32'(done_cnt[d]), 32'(target));
  endtask

  task automatic wait_zero_poll(input int d);
    int n = 0;
    int base_cnt;
    base_cnt = zero_cnt[d];
    while (zero_cnt[d] == base_cnt && n < 500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("zero poll seen d%0d", d), 1'(zero_cnt[d] > base_cnt), 1'b1);
  endtask

  task automatic check_order(input int d, input int nfilt);
    logic [31:0] exp_off[11];
    logic [31:0] got;
    int n, len;
    n = 4 + nfilt;
    exp_off[0] = 32'h120; exp_off[1] = 32'h000; exp_off[2] = 32'h020; exp_off[3] = 32'h100;
    for (int k = 0; k < nfilt; k++) exp_off[4+k] = 32'h40 + 32'(4 * k);
    len = (d == 0) ? alog0.size() : alog1.size();
    check($sformatf("addr log long enough d%0d", d), 1'(len >= n), 1'b1);
    if (len >= n) begin
      for (int i = 0; i < n; i++) begin
        got = (d == 0) ? alog0[len-n+i] : alog1[len-n+i];
        check($sformatf("addr order d%0d #%0d", d, i), got, BASE + exp_off[i]);
      end
    end
  endtask

  task automatic pulse_fpu_a();
    @(negedge clk); fpu_a = 1'b1;
    @(negedge clk); fpu_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fpu_a = 1'b0; fpu_b = 1'b0; lat_fix = 0;
    spur[0] = 1'b0; spur[1] = 1'b0;
    for (int d = 0; d < 2; d++) for (int k = 0; k < 7; k++) filtw[d][k] = 32'h0;

    startsig[0] = 32'h1; dims[0] = {16'd300, 16'd10}; startv[0] = 32'h1234; resv[0] = 32'h0;
    filtw[0][0] = 32'h01FF_0001; filtw[0][1] = 32'h01FF_00FF; filtw[0][2] = 32'h01AB_CDEF;

    startsig[1] = 32'h1; dims[1] = {16'd5, 16'd7}; startv[1] = 32'hAAAA_0000; resv[1] = 32'hBBBB_0000;
    filtw[1][0] = 32'h80FF_7F01; filtw[1][1] = 32'h0405_0607; filtw[1][2] = 32'h0809_0A0B;
    filtw[1][3] = 32'h0C0D_0E0F; filtw[1][4] = 32'h1011_1213; filtw[1][5] = 32'h1415_1617;
    filtw[1][6] = 32'h185A_5A5A;

    repeat (3) @(negedge clk);
    check("reset req",      req_a,  1'b0);
    check("reset addr",     addr_a, 32'h0);
    check("reset width",    w_a,    16'h0);
    check("reset height",   h_a,    16'h0);
    check("reset start",    sa_a,   32'h0);
    check("reset result",   ra_a,   32'h0);
    check("reset filter",   filt_a, 72'h0);
    check("reset done",     done_a, 1'b0);
    check("reset busy",     busy_a, 1'b0);
    check("reset cfg_err",  err_a,  1'b0);
    check("reset filter b", filt_b, 200'h0);

    rst = 1'b0;
    @(posedge clk); #1;
    check("first req",  req_a,  1'b1);
    check("first addr", addr_a, BASE + 32'h120);

    // Job 1: both instances load concurrently.
    wait_done(0, 1);
    wait_done(1, 1);
    @(negedge clk);
    check("j1 width",   w_a,    16'd300);
    check("j1 height",  h_a,    16'd10);
    check("j1 start",   sa_a,   32'h1234);
    check("j1 result",  ra_a,   32'h0);
    check("j1 filter",  filt_a, 72'h01FF00FF010100FF01);
    check("j1 busy",    busy_a, 1'b1);
    check("j1 cfg_err", err_a,  1'b0);
    check("j1 log size", 32'(alog0.size()), 32'd7);
    check_order(0, 3);
    check("k5 width",  w_b,    16'd5);
    check("k5 height", h_b,    16'd7);
    check("k5 start",  sa_b,   32'hAAAA_0000);
    check("k5 result", ra_b,   32'hBBBB_0000);
    check("k5 filter", filt_b, 200'h181716151413121110_0F0E0D0C0B0A090807060504_017FFF80);
    check_order(1, 7);

    // Start register stays high across fpu_done: no relaunch.
    pulse_fpu_a();
    check("j1 busy after done", busy_a, 1'b0);
    repeat (150) @(negedge clk);
    check("no retrigger count", 32'(done_cnt[0]), 32'd1);
    check("no retrigger busy",  busy_a, 1'b0);

    dims[0] = {16'd160, 16'd1080}; startv[0] = 32'h2000_0000; resv[0] = 32'h3000_0000;
    startsig[0] = 32'h0;
    wait_zero_poll(0);
    startsig[0] = 32'h1;
    wait_done(0, 2);
    @(negedge clk);
    check("j2 width",  w_a,  16'd160);
    check("j2 height", h_a,  16'd1080);
    check("j2 start",  sa_a, 32'h2000_0000);
    check("j2 result", ra_a, 32'h3000_0000);

    // Zero width: error, outputs kept.
    pulse_fpu_a();
    startsig[0] = 32'h0;
    wait_zero_poll(0);
    dims[0] = {16'd0, 16'd5};
    startsig[0] = 32'h1;
    begin
      int n = 0;
      while (err_a !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    check("err set",        err_a,  1'b1);
    check("err busy in ERR", busy_a, 1'b1);
    @(negedge clk);
    check("err busy drop",  busy_a, 1'b0);
    check("err no load",    32'(done_cnt[0]), 32'd2);
    check("err width kept", w_a,    16'd160);
    check("err height kept", h_a,   16'd1080);
    check("err start kept", sa_a,   32'h2000_0000);
    check("err filter kept", filt_a, 72'h01FF00FF010100FF01);

    // Valid job with stray valid strobes in every request gap; clears cfg_error.
    spur[0] = 1'b1;
    startsig[0] = 32'h0;
    wait_zero_poll(0);
    dims[0] = {16'd64, 16'd32}; startv[0] = 32'h4000; resv[0] = 32'h5000;
    startsig[0] = 32'h1;
    wait_done(0, 3);
    @(negedge clk);
    spur[0] = 1'b0;
    check("j4 cfg_err clear", err_a, 1'b0);
    check("j4 width",  w_a,    16'd64);
    check("j4 height", h_a,    16'd32);
    check("j4 start",  sa_a,   32'h4000);
    check("j4 result", ra_a,   32'h5000);
    check("j4 filter", filt_a, 72'h01FF00FF010100FF01);
    check_order(0, 3);

    // Reset while the second filter word is outstanding.
    pulse_fpu_a();
    startsig[0] = 32'h0;
    wait_zero_poll(0);
    dims[0] = {16'd32, 16'd16}; startv[0] = 32'h6000; resv[0] = 32'h7000;
    lat_fix = 8;
    startsig[0] = 32'h1;
    begin
      int n = 0;
      while (!(pend[0] && pend_addr[0] == BASE + 32'h44) && n < 2000) begin
        @(posedge clk);
        n++;
      end
      check("reached 2nd filter read", 1'(pend[0] && pend_addr[0] == BASE + 32'h44), 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    check("mid rst width",  w_a,    16'h0);
    check("mid rst height", h_a,    16'h0);
    check("mid rst start",  sa_a,   32'h0);
    check("mid rst result", ra_a,   32'h0);
    check("mid rst filter", filt_a, 72'h0);
    check("mid rst req",    req_a,  1'b0);
    check("mid rst addr",   addr_a, 32'h0);
    check("mid rst busy",   busy_a, 1'b0);
    lat_fix = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post rst req",  req_a,  1'b1);
    check("post rst addr", addr_a, BASE + 32'h120);
    wait_done(0, 4);
    @(negedge clk);
    check("reload width",   w_a,    16'd32);
    check("reload height",  h_a,    16'd16);
    check("reload start",   sa_a,   32'h6000);
    check("reload result",  ra_a,   32'h7000);
    check("reload filter",  filt_a, 72'h01FF00FF010100FF01);
    check("reload cfg_err", err_a,  1'b0);
    check_order(0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
